fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 15 +
 rtl/next_pc_calc.sv | 15 +
 rtl/fetch_unit.sv | 72 +++++++
 tb/tb_fetch_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch FSM encoding, opcode constants and default reset PC
package mips_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } fetch_state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC select (jump > taken branch > sequential)
module next_pc_calc (
  input  logic [31:0] i_pc_plus4,
  input  logic [25:0] i_instr,
  input  logic        i_jump,
  input  logic        i_branch,
  input  logic        i_zero,
  output logic [31:0] o_next_pc
);
  logic [31:0] w_jump_pc;
  logic [31:0] w_br_pc;
  assign w_jump_pc = {i_pc_plus4[31:28], i_instr, 2'b00};
  assign w_br_pc   = i_pc_plus4 + {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
  assign o_next_pc = i_jump ? w_jump_pc : (i_branch && i_zero) ? w_br_pc : i_pc_plus4;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/FETCH/ISSUE instruction fetch; FETCH_STALL_CNT_EN enables the imem wait-cycle counter
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op_code,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] stall_cnt
);
  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  w_next_pc;
  logic         w_capture;
  logic         w_accept;
  assign imem_req    = r_state == ST_FETCH;
  assign instr_valid = r_state == ST_ISSUE;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign op_code     = r_instr[31:26];
  assign pc_plus4    = r_pc + 32'd4;
  assign w_capture   = imem_req && imem_ack;
  assign w_accept    = instr_valid && instr_ready;
  always_comb
    w_state_nxt = (r_state == ST_IDLE) ? ST_FETCH :
                  w_capture            ? ST_ISSUE :
                  w_accept             ? ST_FETCH : r_state;
  // PC only moves on accept, so pc_plus4 stays tied to the presented instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_instr <= imem_rdata;
      if (w_accept) r_pc <= w_next_pc;
    end
  end
  next_pc_calc u_next_pc (
    .i_pc_plus4 (pc_plus4),
    .i_instr    (r_instr[25:0]),
    .i_jump     (jump),
    .i_branch   (branch),
    .i_zero     (zero),
    .o_next_pc  (w_next_pc)
  );
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_stall_cnt <= '0;
    else if (imem_req && !imem_ack && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
  end
  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized check of fetch_unit against a transaction-level model
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, imem_ack, instr_ready, jump, branch, zero;
  logic [31:0] imem_rdata;
  logic        a_req, a_valid, b_req, b_valid;
  logic [31:0] a_addr, a_instr, a_pp4, a_stall, b_addr, b_instr, b_pp4, b_stall;
  logic [5:0]  a_op, b_op;
  int          n_chk = 0;
  int          n_bad = 0;
  bit          m_known = 0, m_idle, m_have;
  logic [31:0] m_pc [2];
  logic [31:0] m_instr, m_stall;

  always #5 clk = ~clk;

  fetch_unit u_dut_a (
    .clk(clk), .rst(rst), .imem_req(a_req), .imem_addr(a_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(a_instr), .op_code(a_op), .pc_plus4(a_pp4),
    .instr_valid(a_valid), .instr_ready(instr_ready), .jump(jump), .branch(branch),
    .zero(zero), .stall_cnt(a_stall)
  );
  fetch_unit #(.RESET_PC(32'h4000_0010)) u_dut_b (
    .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(b_instr), .op_code(b_op), .pc_plus4(b_pp4),
    .instr_valid(b_valid), .instr_ready(instr_ready), .jump(jump), .branch(branch),
    .zero(zero), .stall_cnt(b_stall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] npc(input logic [31:0] pc, input logic [31:0] ins,
                                      input bit j, input bit b, input bit z);
    int off;
    off = int'($signed(ins[15:0]));
    if (j) return ((pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (b && z) return pc + 32'd4 + 32'(off * 4);
    return pc + 32'd4;
  endfunction

  task automatic compare();
    logic [31:0] exp_stall;
`ifdef FETCH_STALL_CNT_EN
    exp_stall = m_stall;
`else
    exp_stall = 32'd0;
`endif
    chk("req_a", {31'd0, a_req}, {31'd0, !m_idle && !m_have});
    chk("req_b", {31'd0, b_req}, {31'd0, !m_idle && !m_have});
    chk("valid_a", {31'd0, a_valid}, {31'd0, m_have});
    chk("valid_b", {31'd0, b_valid}, {31'd0, m_have});
    chk("instr_a", a_instr, m_instr);
    chk("stall_a", a_stall, exp_stall);
    chk("stall_b", b_stall, exp_stall);
    if (!m_idle && !m_have) begin
      chk("addr_a", a_addr, m_pc[0]);
      chk("addr_b", b_addr, m_pc[1]);
    end
    if (m_have) begin
      chk("op_a", {26'd0, a_op}, {26'd0, m_instr[31:26]});
      chk("pp4_a", a_pp4, m_pc[0] + 32'd4);
      chk("pp4_b", b_pp4, m_pc[1] + 32'd4);
    end
  endtask

  // drive one cycle of inputs, advance the model, then compare after the edge
  task automatic tick(input bit r, input bit a, input bit rd, input bit j, input bit b,
                      input bit z, input logic [31:0] d);
    rst = r; imem_ack = a; instr_ready = rd; jump = j; branch = b; zero = z; imem_rdata = d;
    if (r) begin
      m_known = 1; m_idle = 1; m_have = 0; m_instr = '0; m_stall = '0;
      m_pc[0] = 32'h0; m_pc[1] = 32'h4000_0010;
    end else if (m_known) begin
      if (m_idle) m_idle = 0;
      else if (!m_have) begin
        if (a) begin m_have = 1; m_instr = d; end
        else if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      end else if (rd) begin
        for (int k = 0; k < 2; k++) m_pc[k] = npc(m_pc[k], m_instr, j, b, z);
        m_have = 0;
      end
    end
    @(negedge clk);
    if (m_known) compare();
  endtask

  initial begin
    rst = 1; imem_ack = 0; instr_ready = 0; jump = 0; branch = 0; zero = 0; imem_rdata = '0;
    @(negedge clk);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0, 0);
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_instr", a_instr, 32'd0);
    tick(0, 1, 1, 0, 0, 0, 32'hFFFF_FFFF);
    chk("first_req", {31'd0, a_req}, 32'd1);
    chk("first_addr", a_addr, 32'h0);
    tick(0, 1, 0, 0, 0, 0, 32'h8C08_0004);
    chk("lw_valid", {31'd0, a_valid}, 32'd1);
    chk("lw_op", {26'd0, a_op}, 32'h23);
    chk("lw_pp4", a_pp4, 32'h4);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("seq_addr4", a_addr, 32'h4);
    tick(0, 1, 0, 0, 0, 0, 32'h0000_0020);
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("seq_addr8", a_addr, 32'h8);
    tick(0, 1, 0, 0, 0, 0, 32'h0800_0004);
    tick(0, 0, 1, 1, 0, 0, 0);
    chk("jump_0x10", a_addr, 32'h10);
    tick(0, 1, 0, 0, 0, 0, 32'h1000_0003);
    tick(0, 0, 1, 0, 1, 1, 0);
    chk("beq_taken", a_addr, 32'h20);
    tick(0, 1, 0, 0, 0, 0, 32'h0800_0004);
    tick(0, 0, 1, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 32'h1000_0003);
    tick(0, 0, 1, 0, 1, 0, 0);
    chk("beq_not_taken", a_addr, 32'h14);
    tick(0, 1, 0, 0, 0, 0, 32'h0800_0004);
    tick(0, 0, 1, 1, 0, 0, 0);
    chk("b_pc_0x4000_0010", b_addr, 32'h4000_0010);
    tick(0, 1, 0, 0, 0, 0, 32'h0800_0100);
    tick(0, 0, 1, 1, 1, 1, 0);
    chk("jump_wins", b_addr, 32'h4000_0400);
    tick(0, 1, 0, 0, 0, 0, 32'h2008_0005);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 0, 0, 0, 0, 32'h1234_5678);
      chk("hold_instr", a_instr, 32'h2008_0005);
      chk("hold_noreq", {31'd0, a_req}, 32'd0);
    end
    tick(0, 0, 1, 0, 0, 0, 0);
    chk("after_accept_req", {31'd0, a_req}, 32'd1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_3", a_stall, 32'd3);
`else
    chk("stall_off", a_stall, 32'd0);
`endif
    tick(1, 1, 1, 0, 0, 0, 32'hAAAA_AAAA);
    chk("rst_stall", a_stall, 32'd0);
    chk("rst_noreq", {31'd0, a_req}, 32'd0);
    tick(0, 1, 1, 0, 0, 0, 0);
    chk("rerst_addr", a_addr, 32'h0);
    chk("rerst_req", {31'd0, a_req}, 32'd1);
    for (int i = 0; i < 4000; i++)
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
